cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
// - Arbitrates NREQ functional-unit result producers onto the two common-data-bus lanes that feed the reservation stations' broadcast inputs (alu_res/alu_res_tag, alu_res2/alu_res_tag2).
// - Round-robin fair; up to 2 grants per cycle; registered lane outputs give one cycle of latency from acceptance to broadcast.
// PARAMETERS
// - NREQ  default 4   number of requesters (2..8)
// - DW    default 32  result data width
// - TW    default 5   destination tag width; tag 0 means "no tag"
// PORTS
// - clk         in   1        clock, rising edge
// - rst         in   1        reset, asynchronous, active-low
// - flush       in   1        synchronous squash (branch mispredict)
// - req_valid   in   NREQ     requester i holds a result
// - req_tag     in   NREQ*TW  tag of requester i, in bits [i*TW +: TW]
// - req_data    in   NREQ*DW  data of requester i, in bits [i*DW +: DW]
// - req_ready   out  NREQ     combinational grant; transfer when valid&ready
// - cdb_valid1  out  1        lane 1 broadcast valid (registered)
// - cdb_tag1    out  TW       lane 1 tag
// - cdb_data1   out  DW       lane 1 data
// - cdb_valid2  out  1        lane 2 broadcast valid (registered)
// - cdb_tag2    out  TW       lane 2 tag
// - cdb_data2   out  DW       lane 2 data
// BEHAVIOUR
// - Reset (rst=0, async): all cdb_* outputs 0; round-robin pointer rr=0; req_ready=0 while rst=0.
// - Selection (comb): scan indices rr, rr+1, ..., rr+NREQ-1, all mod NREQ.
//   - First valid index found -> lane 1; second valid index found -> lane 2.
//   - req_ready is 1 only for the (at most 2) selected indices.
// - Requesters hold valid/tag/data stable until ready; the arbiter never drops an accepted request.
// - Lane register update (every clk edge):
//   - Lane n has a grant: cdb_valid_n=1; tag/data = the granted requester's values.
//   - Lane n has no grant: cdb_valid_n=0; tag and data forced to 0.
//   - Tag 0 is therefore never seen with valid=1 unless a requester sent tag 0; a 0 tag never matches a real RS operand tag.
// - Pointer update:
//   - rr <- (last granted index + 1) mod NREQ.
//   - No grant: rr unchanged.
//   - Wrap: NREQ-1 granted last -> rr=0.
// - Only one valid requester: it takes lane 1; lane 2 is idle.
// - More than 2 valid requesters: the rest see ready=0 and are retried the next cycle.
//   - Fairness: a continuously valid requester is granted within ceil(NREQ/2) cycles.
// - flush=1:
//   - req_ready=0 for all requesters; no transfers occur.
//   - Next edge: cdb_* cleared to 0 and rr <- 0.
//   - flush has priority over every grant.
// - Reset asserted mid-operation: outputs clear immediately (async); in-flight lane contents are lost by design.
// - Output validity: req_ready must not depend on cdb_* outputs (no comb loop).
// CONFIGURATION
// - Macro CDB_STALL_STATS_EN.
//   - Defined: adds output stall_cnt [15:0].
//     - Increments on each cycle where one or more valid requesters got ready=0 and flush=0.
//     - Saturates at 16'hFFFF.
//     - Reset to 0 by rst; not cleared by flush.
//   - Undefined: no stall_cnt port; no counter logic; all other behaviour identical.
// TESTING
// - Reset: rst=0 with req_valid=4'b1111 -> req_ready=0, cdb_valid1/2=0, tags/data 0; release -> first cycle grants idx0, idx1.
// - Single request: req_valid=4'b0100, tag=7, data=32'hDEAD_BEEF
//   - ready=4'b0100 the same cycle.
//   - Next cycle: cdb_valid1=1, cdb_tag1=7, cdb_data1=DEADBEEF; cdb_valid2=0, cdb_tag2=0.
// - Round-robin, all 4 valid for 4 cycles (rr=0):
//   - Grants in order {0,1}, {2,3}, {0,1}, {2,3}; rr sequence 0, 2, 0, 2.
// - Wrap: rr=3, req_valid=4'b1001 -> lane1 = idx3, lane2 = idx0; next rr=1.
// - Flush: all valid, flush=1 for 1 cycle
//   - req_ready=0 during flush; next cycle cdb_valid1/2=0 and rr=0.
//   - Following cycle grants {0,1}.
// - Stats (CDB_STALL_STATS_EN): 3 valid requesters held 5 cycles -> stall_cnt=5; forced near max -> holds at FFFF.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that places up to two functional-unit results per cycle onto the two CDB lanes.
// Optional macro CDB_STALL_STATS_EN adds a saturating stall_cnt output.
module cdb_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int TW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*TW-1:0] req_tag,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              cdb_valid1,
  output logic [TW-1:0]     cdb_tag1,
  output logic [DW-1:0]     cdb_data1,
  output logic              cdb_valid2,
  output logic [TW-1:0]     cdb_tag2,
  output logic [DW-1:0]     cdb_data2
`ifdef CDB_STALL_STATS_EN
  ,output logic [15:0]      stall_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr;
  logic [PW-1:0]   sel1_idx, sel2_idx, last_idx;
  logic            sel1_found, sel2_found;
  logic [NREQ-1:0] grant;
  logic [TW-1:0]   tag_arr  [NREQ];
  logic [DW-1:0]   data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign tag_arr[g]  = req_tag[g*TW +: TW];
    assign data_arr[g] = req_data[g*DW +: DW];
  end

  // Scan from the round-robin pointer; the first two valid requesters win lanes 1 and 2.
  always_comb begin
    logic [PW:0] scan;
    sel1_found = 1'b0;
    sel2_found = 1'b0;
    sel1_idx   = '0;
    sel2_idx   = '0;
    scan       = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr} + (PW+1)'(k);
      if (scan >= (PW+1)'(NREQ))
        scan = scan - (PW+1)'(NREQ);
      if (req_valid[scan[PW-1:0]]) begin
        if (!sel1_found) begin
          sel1_found = 1'b1;
          sel1_idx   = scan[PW-1:0];
        end else if (!sel2_found) begin
          sel2_found = 1'b1;
          sel2_idx   = scan[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (sel1_found)
      grant[sel1_idx] = 1'b1;
    if (sel2_found)
      grant[sel2_idx] = 1'b1;
  end

  // Ready depends only on inputs and rr, never on the lane registers.
  assign req_ready = (rst && !flush) ? grant : '0;
  assign last_idx  = sel2_found ? sel2_idx : sel1_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr         <= '0;
      cdb_valid1 <= 1'b0;
      cdb_tag1   <= '0;
      cdb_data1  <= '0;
      cdb_valid2 <= 1'b0;
      cdb_tag2   <= '0;
      cdb_data2  <= '0;
    end else if (flush) begin
      rr         <= '0;
      cdb_valid1 <= 1'b0;
      cdb_tag1   <= '0;
      cdb_data1  <= '0;
      cdb_valid2 <= 1'b0;
      cdb_tag2   <= '0;
      cdb_data2  <= '0;
    end else begin
      cdb_valid1 <= sel1_found;
      cdb_tag1   <= sel1_found ? tag_arr[sel1_idx]  : '0;
      cdb_data1  <= sel1_found ? data_arr[sel1_idx] : '0;
      cdb_valid2 <= sel2_found;
      cdb_tag2   <= sel2_found ? tag_arr[sel2_idx]  : '0;
      cdb_data2  <= sel2_found ? data_arr[sel2_idx] : '0;
      if (sel1_found)
        rr <= (last_idx == PW'(NREQ-1)) ? '0 : last_idx + 1'b1;
    end
  end

`ifdef CDB_STALL_STATS_EN
  logic stall;
  assign stall = !flush && |(req_valid & ~grant);

  // Flush deliberately does not clear the statistic; only reset does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
`endif

endmodule
